// File: rtl/tdm_demux_8to1_if.sv
// Bus bundle for the 8-slot TDM demultiplexer: serial sample stream in,
// assembled frame plus status out.
interface tdm_demux_8to1_if #(
  parameter int W = 1
);
  logic [W-1:0]   din;
  logic           din_valid;
  logic           sof;
  logic [8*W-1:0] y;
  logic           frame_valid;
  logic [2:0]     sel;
  logic           locked;
  logic           sync_err;

  modport master (
    output din, din_valid, sof,
    input  y, frame_valid, sel, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sof,
    output y, frame_valid, sel, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_8to1.sv
// Receive-side 8:1 TDM demultiplexer. A channel counter tracks the slot
// position, a shadow register collects the frame, and only complete frames
// are published on y. Misaligned or missing start-of-frame is flagged and
// the block resynchronises on the next sof.
//
// state | meaning
// HUNT  | unlocked, discarding samples until one arrives with sof
// RUN   | locked, sel names the slot expected for the next accepted sample
module tdm_demux_8to1 #(
  parameter int W = 1
) (
  input  logic              clk,
  input  logic              rst,
  tdm_demux_8to1_if.slave   bus
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q, state_n;
  logic [2:0]     sel_q, sel_n;
  logic [8*W-1:0] shadow_q, shadow_n;
  logic [8*W-1:0] y_q, y_n;
  logic           fv_q, fv_n;
  logic           err_q, err_n;

  // State register: FSM state, slot counter, shadow/frame data and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      sel_q    <= 3'd0;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      sel_q    <= sel_n;
      shadow_q <= shadow_n;
      y_q      <= y_n;
      fv_q     <= fv_n;
      err_q    <= err_n;
    end
  end

  // Next-state logic: only accepted samples move anything; strobes self-clear.
  always_comb begin
    state_n  = state_q;
    sel_n    = sel_q;
    shadow_n = shadow_q;
    y_n      = y_q;
    fv_n     = 1'b0;
    err_n    = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sof) begin
            shadow_n[W-1:0] = bus.din;
            sel_n           = 3'd1;
            state_n         = RUN;
          end
        end
        RUN: begin
          if (bus.sof) begin
            // sof always restarts the frame; off slot 0 it also drops the partial one
            err_n           = (sel_q != 3'd0);
            shadow_n[W-1:0] = bus.din;
            sel_n           = 3'd1;
          end else if (sel_q == 3'd0) begin
            err_n   = 1'b1;
            state_n = HUNT;
          end else if (sel_q == 3'd7) begin
            y_n   = {bus.din, shadow_q[7*W-1:0]};
            fv_n  = 1'b1;
            sel_n = 3'd0;
          end else begin
            shadow_n[int'(sel_q)*W +: W] = bus.din;
            sel_n                        = sel_q + 3'd1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // Output logic: every output is a direct register copy, no input paths.
  always_comb begin
    bus.y           = y_q;
    bus.frame_valid = fv_q;
    bus.sel         = sel_q;
    bus.locked      = (state_q == RUN);
    bus.sync_err    = err_q;
  end

endmodule

// File: doc/tdm_demux_8to1.md
# tdm_demux_8to1

Receive-side counterpart of the 8:1 multiplexer: a time-division demultiplexer that takes one serial sample stream and distributes it across 8 channel slots. The transmitter visits channels 0..7 in order and marks channel 0 with a start-of-frame flag. This block tracks the channel index with an internal counter, assembles each 8-slot frame in a shadow register, and presents complete frames on a parallel bus with a one-cycle valid strobe. It detects and reports frame misalignment and resynchronises on the next start-of-frame.

## Interface
- W, default 1: width of one channel sample in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  serial sample for the current channel slot.
- din_valid  input  1  din carries a sample this cycle. Slot accepted only when high.
- sof  input  1  start of frame. Qualified by din_valid; marks din as channel 0.
- y  output  8*W  last complete frame. Channel k occupies y[k*W +: W].
- frame_valid  output  1  one-cycle pulse; y was updated on the preceding edge.
- sel  output  3  channel index expected for the next accepted sample. sel[2:0] maps to {en0,en1,en2} of the mux select, MSB first.
- locked  output  1  high while in RUN.
- sync_err  output  1  one-cycle pulse on a misaligned sof or a missing sof.

## Operation
- Reset values: y=0, frame_valid=0, sel=0, locked=0, sync_err=0. Shadow register is 0 and the FSM is in HUNT.
- A sample is accepted when din_valid=1. Cycles with din_valid=0 change no state, and sof is ignored when din_valid=0.
- HUNT:
  - Accepted samples without sof are discarded and sel stays 0.
  - An accepted sample with sof is stored in shadow slot 0, sel becomes 1, and the FSM moves to RUN.
- RUN, on each accepted sample:
  - Slots 1..6 (sof=0): store din in shadow slot sel, then sel increments.
  - Slot 7 (sof=0): y takes shadow slots 0..6 with din as slot 7. frame_valid is set for the next cycle and sel wraps to 0.
  - Sample at sel=0 with sof=1: normal frame start. Store in slot 0, sel becomes 1.
  - Sample at sel=0 with sof=0: missing sof. sync_err pulses, the sample is discarded, the FSM returns to HUNT and sel stays 0.
  - Sample at sel≠0 with sof=1: misaligned sof. sync_err pulses and the partial frame is dropped (y unchanged, no frame_valid). The sample is stored as slot 0, sel becomes 1 and the FSM stays in RUN.
- Shadow slots not yet written in the current frame keep stale data. Only full frames reach y.
- rst asserted mid-frame clears everything immediately, asynchronously. The partial frame is lost and no frame_valid is produced.

## Timing
- Latency: the edge that accepts slot 7 updates y. frame_valid is high in the cycle following that edge, for exactly one cycle.
- Back-to-back frames need 8 accepted samples each. Peak throughput is one frame per 8 cycles, and frame_valid pulses are then 8 cycles apart.
- sel and locked are registered and change on the accepting edge. sync_err is registered and high for the one cycle after the offending edge.
- Simultaneous events:
  - A misaligned sof on what would be slot 7: the sof rule wins and y is not updated.
  - Slot 7 accepted while frame_valid is still high from the previous frame is impossible. Frames need at least 8 cycles.
- All outputs are glitch-free registered values. There are no combinational paths from input to output.

## Test plan
- Reset then idle: rst pulse, inputs 0 for 20 cycles -> y=0, sel=0, locked=0, frame_valid and sync_err never high.
- Single frame, W=1: with din_valid=1 and sof on slot 0, send 1,0,1,1,0,0,1,0 for channels 0..7 -> y=8'b0100_1101, frame_valid high exactly one cycle after slot 7, locked=1, sel back to 0.
- Gaps and back-to-back: same frame with din_valid=0 inserted between slots 3 and 4 for 5 cycles, then a second frame at 1 sample/cycle with data 8'hA5 -> first y unchanged through the gap, then 8'b0100_1101, then 8'hA5. frame_valid pulses are 8 cycles apart for the back-to-back pair.
- Misaligned sof: sof at sel=5 mid-frame -> sync_err one cycle, no frame_valid, sel=1. The following 7 samples complete a frame and y reflects the new frame only.
- Missing sof: after a good frame, a sample at sel=0 with sof=0 -> sync_err, locked=0. The next sof relocks and a full frame updates y.
- Reset mid-frame: assert rst after slot 3 -> all outputs 0 at once, FSM in HUNT. The remaining slots without sof are ignored and y stays 0.
